// File: rtl/peak_voltage_tracker.sv
// Peak search over one servo sweep: keeps the largest ADC sample, compared on its upper bits, with the matching position.
// Define PEAK_HYST_EN to require a HYST margin above the stored peak before a new sample may replace it.
module peak_voltage_tracker #(
   parameter int WIDTH      = 12,
   parameter int IGNORE_LSB = 4,
   parameter int POS_WIDTH  = 8,
   parameter int HYST       = 1,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 SAMPLE_VALID,
   input  logic [WIDTH-1:0]     SAMPLE,
   input  logic [POS_WIDTH-1:0] POS,
   input  logic                 SWEEP_END,
   output logic                 GT,
   output logic [WIDTH-1:0]     PEAK_VAL,
   output logic [POS_WIDTH-1:0] PEAK_POS,
   output logic [CNT_WIDTH-1:0] SAMPLE_CNT,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int FW = WIDTH - IGNORE_LSB;

   if (IGNORE_LSB < 0 || IGNORE_LSB >= WIDTH || HYST < 0) begin : g_bad_param
      $error("peak_voltage_tracker: IGNORE_LSB must be 0..WIDTH-1 and HYST non-negative");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       peak_val_q, peak_val_d;
   logic [POS_WIDTH-1:0]   peak_pos_q, peak_pos_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   gt_q, gt_d;
   logic                   first_q, first_d;

   logic [FW-1:0]          s_field;
   logic [FW-1:0]          p_field;
   logic                   beats_peak;
   logic                   accept;

   assign s_field = SAMPLE[WIDTH-1:IGNORE_LSB];
   assign p_field = peak_val_q[WIDTH-1:IGNORE_LSB];

`ifdef PEAK_HYST_EN
   // One extra bit so a peak near full scale pushes the threshold out of reach instead of wrapping.
   localparam logic [FW:0] HYST_EXT = (FW+1)'(HYST);
   assign beats_peak = {1'b0, s_field} > ({1'b0, p_field} + HYST_EXT);
`else
   assign beats_peak = s_field > p_field;
`endif

   // START owns its cycle: a sample presented alongside it is dropped.
   assign accept = (state_q == ST_SWEEP) && SAMPLE_VALID && !START;

   always_comb begin
      state_d    = state_q;
      peak_val_d = peak_val_q;
      peak_pos_d = peak_pos_q;
      cnt_d      = cnt_q;
      gt_d       = 1'b0;
      first_d    = first_q;

      if (START) begin
         state_d    = ST_SWEEP;
         peak_val_d = '0;
         peak_pos_d = '0;
         cnt_d      = '0;
         first_d    = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_SWEEP: begin
               if (accept) begin
                  if (first_q || beats_peak) begin
                     peak_val_d = SAMPLE;
                     peak_pos_d = POS;
                     gt_d       = 1'b1;
                  end
                  first_d = 1'b0;
                  if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               if (SWEEP_END) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         peak_val_q <= '0;
         peak_pos_q <= '0;
         cnt_q      <= '0;
         gt_q       <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         peak_val_q <= peak_val_d;
         peak_pos_q <= peak_pos_d;
         cnt_q      <= cnt_d;
         gt_q       <= gt_d;
         first_q    <= first_d;
      end
   end

   assign GT         = gt_q;
   assign PEAK_VAL   = peak_val_q;
   assign PEAK_POS   = peak_pos_q;
   assign SAMPLE_CNT = cnt_q;
   assign BUSY       = (state_q == ST_SWEEP);
   assign DONE       = (state_q == ST_DONE);

endmodule

// File: tb/tb_peak_voltage_tracker.sv
// Directed and random checks of peak_voltage_tracker against a sweep-level reference model.
module tb_peak_voltage_tracker;

   localparam int WIDTH = 12;
   localparam int IGN   = 4;
   localparam int PW    = 8;
   localparam int CW    = 10;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef PEAK_HYST_EN
   localparam int HYSTM = 1;
`else
   localparam int HYSTM = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              valid = 1'b0;
   logic [WIDTH-1:0]  sample = '0;
   logic [PW-1:0]     pos = '0;
   logic              send = 1'b0;
   logic              gt;
   logic [WIDTH-1:0]  peak_val;
   logic [PW-1:0]     peak_pos;
   logic [CW-1:0]     sample_cnt;
   logic              busy;
   logic              done;

   int errors = 0;
   int checks = 0;

   // Reference model state, kept as plain integers
   int  m_peak = 0;
   int  m_pos = 0;
   int  m_cnt = 0;
   bit  m_gt = 0;
   bit  m_first = 0;
   bit  m_in_sweep = 0;
   bit  m_done = 0;

   always #5 clk = ~clk;

   peak_voltage_tracker #(
      .WIDTH(WIDTH), .IGNORE_LSB(IGN), .POS_WIDTH(PW), .HYST(1), .CNT_WIDTH(CW)
   ) dut (
      .CLK(clk), .RST(rst), .START(start), .SAMPLE_VALID(valid), .SAMPLE(sample),
      .POS(pos), .SWEEP_END(send), .GT(gt), .PEAK_VAL(peak_val), .PEAK_POS(peak_pos),
      .SAMPLE_CNT(sample_cnt), .BUSY(busy), .DONE(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // What one clock edge does to the sweep, stated in terms of the block's rules.
   task automatic model_edge(input bit r, input bit st, input bit v, input int s, input int p, input bit e);
      if (r) begin
         m_peak = 0; m_pos = 0; m_cnt = 0; m_gt = 0; m_first = 0; m_in_sweep = 0; m_done = 0;
      end else if (st) begin
         m_peak = 0; m_pos = 0; m_cnt = 0; m_gt = 0; m_first = 1; m_in_sweep = 1; m_done = 0;
      end else begin
         m_gt = 0;
         m_done = 0;
         if (m_in_sweep) begin
            if (v) begin
               if (m_first || ((s >> IGN) > (m_peak >> IGN) + HYSTM)) begin
                  m_peak = s; m_pos = p; m_gt = 1;
               end
               m_first = 0;
               if (m_cnt < CMAX) m_cnt++;
            end
            if (e) begin
               m_in_sweep = 0;
               m_done = 1;
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit st, input bit v, input int s, input int p, input bit e);
      rst = r; start = st; valid = v; sample = WIDTH'(s); pos = PW'(p); send = e;
      @(posedge clk);
      model_edge(r, st, v, s, p, e);
      #1;
      $display("step rst=%0b start=%0b valid=%0b sample=%03h pos=%0d end=%0b -> gt=%0b peak=%03h@%0d cnt=%0d busy=%0b done=%0b",
               r, st, v, s, p, e, gt, peak_val, peak_pos, sample_cnt, busy, done);
      check("gt", 32'(gt), 32'(m_gt));
      check("peak_val", 32'(peak_val), 32'(m_peak));
      check("peak_pos", 32'(peak_pos), 32'(m_pos));
      check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
      check("busy", 32'(busy), 32'(m_in_sweep));
      check("done", 32'(done), 32'(m_done));
      rst = 0; start = 0; valid = 0; send = 0;
   endtask

   initial begin
      // Reset
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 'h123, 5, 0);
      check("reset_peak", 32'(peak_val), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);

      // Basic sweep
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 'h100, 0, 0);
      check("basic_gt0", 32'(gt), 32'h1);
      step(0, 0, 1, 'h300, 1, 0);
      check("basic_gt1", 32'(gt), 32'h1);
      step(0, 0, 1, 'h200, 2, 0);
      check("basic_gt2", 32'(gt), 32'h0);
      step(0, 0, 0, 0, 0, 1);
      check("basic_done", 32'(done), 32'h1);
      check("basic_peak", 32'(peak_val), 32'h300);
      check("basic_pos", 32'(peak_pos), 32'h1);
      check("basic_cnt", 32'(sample_cnt), 32'h3);
      step(0, 0, 0, 0, 0, 0);
      check("basic_done_once", 32'(done), 32'h0);
      check("basic_busy_after", 32'(busy), 32'h0);
      check("basic_hold_peak", 32'(peak_val), 32'h300);

      // Ignored LSBs and hysteresis
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 'h300, 0, 0);
      step(0, 0, 1, 'h30F, 1, 0);
      check("ign_lsb_gt", 32'(gt), 32'h0);
      step(0, 0, 1, 'h310, 2, 0);
`ifdef PEAK_HYST_EN
      check("hyst_310_gt", 32'(gt), 32'h0);
      check("hyst_310_peak", 32'(peak_val), 32'h300);
`else
      check("nohyst_310_gt", 32'(gt), 32'h1);
      check("nohyst_310_peak", 32'(peak_val), 32'h310);
`endif
      step(0, 0, 1, 'h320, 3, 1);
      check("hyst_320_peak", 32'(peak_val), 32'h320);
      step(0, 0, 0, 0, 0, 0);

      // Tie and saturation of the compared field
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 'hFF0, 4, 0);
      step(0, 0, 1, 'hFFF, 9, 0);
      check("tie_pos", 32'(peak_pos), 32'h4);
      step(0, 0, 1, 'hFF8, 7, 1);
      check("tie_peak", 32'(peak_val), 32'hFF0);

      // SWEEP_END with a sample in the same cycle
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 'h200, 1, 0);
      step(0, 0, 1, 'h500, 2, 1);
      check("end_with_sample_peak", 32'(peak_val), 32'h500);
      check("end_with_sample_done", 32'(done), 32'h1);
      step(0, 1, 0, 0, 0, 0);   // START while in DONE

      // START mid-sweep, then a lower sample must load as first
      step(0, 0, 1, 'h700, 1, 0);
      step(0, 1, 1, 'h7F0, 2, 0);
      check("restart_clear_peak", 32'(peak_val), 32'h0);
      check("restart_clear_cnt", 32'(sample_cnt), 32'h0);
      step(0, 0, 1, 'h050, 3, 0);
      check("restart_first_load", 32'(peak_val), 32'h050);
      step(0, 0, 0, 0, 0, 1);

      // No-sample sweep
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      check("empty_done", 32'(done), 32'h1);
      check("empty_cnt", 32'(sample_cnt), 32'h0);

      // RST mid-sweep, then samples ignored until START
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 'h444, 6, 0);
      step(1, 0, 1, 'h555, 7, 1);
      check("rst_peak", 32'(peak_val), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      step(0, 0, 1, 'h666, 8, 0);
      step(0, 0, 1, 'h777, 9, 1);
      check("rst_ignored_cnt", 32'(sample_cnt), 32'h0);

      // Counter saturation
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < CMAX + 4; i++) begin
         step(0, 0, 1, int'($urandom_range(0, 4095)), i % 256, 0);
      end
      check("cnt_saturated", 32'(sample_cnt), 32'(CMAX));
      step(0, 0, 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), $urandom_range(0, 24) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
